// File: rtl/ula_sequencer_if.sv
// Request, ULA-drive and response signals of the ULA sequencer bundled as one bus.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface ula_sequencer_if #(
  parameter int N = 8
);
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [2:0]   req_op;

  logic [N-1:0] ula_a;
  logic [N-1:0] ula_b;
  logic [2:0]   ula_selec;
  logic         ula_en;
  logic [N:0]   ula_s;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N:0]   rsp_s;
  logic [2:0]   rsp_op;
  logic         rsp_mismatch;
  logic         rsp_illegal;

  // Environment side: issues requests, implements the ULA, consumes responses.
  modport master (
    output req_valid, req_a, req_b, req_op, ula_s, rsp_ready,
    input  req_ready, ula_a, ula_b, ula_selec, ula_en,
    input  rsp_valid, rsp_s, rsp_op, rsp_mismatch, rsp_illegal
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, ula_s, rsp_ready,
    output req_ready, ula_a, ula_b, ula_selec, ula_en,
    output rsp_valid, rsp_s, rsp_op, rsp_mismatch, rsp_illegal
  );
endinterface

// File: rtl/ula_sequencer.sv
// Drives one request at a time into the combinational ULA, samples S and checks it against a golden model.
// Latency: rsp_valid rises SETTLE edges after the accept edge; an illegal op (111) responds on the accept edge.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready, one transaction in flight.
module ula_sequencer #(
  parameter int N      = 8,
  parameter int SETTLE = 1,
  parameter int CHECK  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ula_sequencer_if.slave bus,
  output logic [7:0]     err_cnt,
  output logic           busy
);

  localparam int cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [cnt_w-1:0] settle_load = cnt_w'(SETTLE - 1);
  localparam bit chk_en = (CHECK != 0);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic [N:0]       expected;
  logic             mismatch;

  // Only the state register decides whether a request can be taken.
  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  // Golden model of the ULA, evaluated on the registered operands actually being driven.
  always_comb begin
    expected = '0;
    case (bus.ula_selec)
      3'b000:  expected = {1'b0, bus.ula_a} + {1'b0, bus.ula_b};
      3'b001:  expected = {1'b0, bus.ula_a} - {1'b0, bus.ula_b};
      3'b010:  expected = {{N{1'b0}}, (bus.ula_a >  bus.ula_b)};
      3'b011:  expected = {{N{1'b0}}, (bus.ula_a <  bus.ula_b)};
      3'b100:  expected = {{N{1'b0}}, (bus.ula_a >= bus.ula_b)};
      3'b101:  expected = {{N{1'b0}}, (bus.ula_a <= bus.ula_b)};
      3'b110:  expected = {{N{1'b0}}, (bus.ula_a == bus.ula_b)};
      default: expected = '0;
    endcase
    mismatch = chk_en && (bus.ula_s != expected);
  end

  // Sequencer FSM: accept, hold the ULA inputs for SETTLE cycles, sample, then wait for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.ula_a        <= '0;
      bus.ula_b        <= '0;
      bus.ula_selec    <= '0;
      bus.ula_en       <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_s        <= '0;
      bus.rsp_op       <= '0;
      bus.rsp_mismatch <= 1'b0;
      bus.rsp_illegal  <= 1'b0;
      err_cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.ula_a     <= bus.req_a;
            bus.ula_b     <= bus.req_b;
            bus.ula_selec <= bus.req_op;
            if (bus.req_op == 3'b111) begin
              // Nothing to compute: answer at once without ever enabling the ULA.
              bus.rsp_s        <= '0;
              bus.rsp_op       <= 3'b111;
              bus.rsp_illegal  <= 1'b1;
              bus.rsp_mismatch <= 1'b0;
              bus.rsp_valid    <= 1'b1;
              state            <= RESP;
            end else begin
              bus.ula_en <= 1'b1;
              cnt        <= settle_load;
              state      <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            bus.rsp_s        <= bus.ula_s;
            bus.rsp_op       <= bus.ula_selec;
            bus.rsp_illegal  <= 1'b0;
            bus.rsp_mismatch <= mismatch;
            if (mismatch && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
            bus.rsp_valid <= 1'b1;
            bus.ula_en    <= 1'b0;
            state         <= RESP;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer: three instances (SETTLE=1/CHECK=1, SETTLE=4/CHECK=1, SETTLE=1/CHECK=0)
// share one stimulus driver; `sel` picks which one is exercised. A behavioural ULA answers each instance.
// Expected responses are queued on request accept and compared at the response handshake.
module tb_ula_sequencer;

  logic clk;
  logic rst_n;

  logic       vld;
  logic       rdy;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       corrupt;
  int         sel;

  int checks;
  int errors;
  int exp_err [3];

  ula_sequencer_if #(.N(8)) i0 ();
  ula_sequencer_if #(.N(8)) i1 ();
  ula_sequencer_if #(.N(8)) i2 ();

  logic [7:0] err0, err1, err2;
  logic       busy0, busy1, busy2;

  ula_sequencer #(.N(8), .SETTLE(1), .CHECK(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(i0.slave), .err_cnt(err0), .busy(busy0));
  ula_sequencer #(.N(8), .SETTLE(4), .CHECK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave), .err_cnt(err1), .busy(busy1));
  ula_sequencer #(.N(8), .SETTLE(1), .CHECK(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(i2.slave), .err_cnt(err2), .busy(busy2));

  // Behavioural ULA; `bad` models a broken ULA that always returns 0.
  function automatic logic [8:0] ula_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] s, input logic bad);
    logic [8:0] r;
    r = 9'd0;
    if (!bad) begin
      case (s)
        3'd0:    r = {1'b0, x} + {1'b0, y};
        3'd1:    r = {1'b0, x} - {1'b0, y};
        3'd2:    r = {8'd0, (x > y)};
        3'd3:    r = {8'd0, (x < y)};
        3'd4:    r = {8'd0, (x >= y)};
        3'd5:    r = {8'd0, (x <= y)};
        3'd6:    r = {8'd0, (x == y)};
        default: r = 9'd0;
      endcase
    end
    return r;
  endfunction

  assign i0.req_valid = vld && (sel == 0);
  assign i1.req_valid = vld && (sel == 1);
  assign i2.req_valid = vld && (sel == 2);
  assign i0.rsp_ready = rdy && (sel == 0);
  assign i1.rsp_ready = rdy && (sel == 1);
  assign i2.rsp_ready = rdy && (sel == 2);
  assign i0.req_a = a;  assign i0.req_b = b;  assign i0.req_op = op;
  assign i1.req_a = a;  assign i1.req_b = b;  assign i1.req_op = op;
  assign i2.req_a = a;  assign i2.req_b = b;  assign i2.req_op = op;
  assign i0.ula_s = ula_model(i0.ula_a, i0.ula_b, i0.ula_selec, corrupt);
  assign i1.ula_s = ula_model(i1.ula_a, i1.ula_b, i1.ula_selec, corrupt);
  assign i2.ula_s = ula_model(i2.ula_a, i2.ula_b, i2.ula_selec, corrupt);

  // Observation of the selected instance, widened for the compare task.
  logic [31:0] m_req_ready, m_rsp_valid, m_ula_en, m_busy, m_mm, m_ill;
  logic [31:0] m_rsp_s, m_rsp_op, m_err, m_ula_a;
  assign m_req_ready = 32'(sel == 0 ? i0.req_ready : sel == 1 ? i1.req_ready : i2.req_ready);
  assign m_rsp_valid = 32'(sel == 0 ? i0.rsp_valid : sel == 1 ? i1.rsp_valid : i2.rsp_valid);
  assign m_ula_en    = 32'(sel == 0 ? i0.ula_en : sel == 1 ? i1.ula_en : i2.ula_en);
  assign m_busy      = 32'(sel == 0 ? busy0 : sel == 1 ? busy1 : busy2);
  assign m_mm        = 32'(sel == 0 ? i0.rsp_mismatch : sel == 1 ? i1.rsp_mismatch : i2.rsp_mismatch);
  assign m_ill       = 32'(sel == 0 ? i0.rsp_illegal : sel == 1 ? i1.rsp_illegal : i2.rsp_illegal);
  assign m_rsp_s     = 32'(sel == 0 ? i0.rsp_s : sel == 1 ? i1.rsp_s : i2.rsp_s);
  assign m_rsp_op    = 32'(sel == 0 ? i0.rsp_op : sel == 1 ? i1.rsp_op : i2.rsp_op);
  assign m_err       = 32'(sel == 0 ? err0 : sel == 1 ? err1 : err2);
  assign m_ula_a     = 32'(sel == 0 ? i0.ula_a : sel == 1 ? i1.ula_a : i2.ula_a);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [8:0] s;
  } vec_t;

  typedef struct packed {
    logic [8:0] s;
    logic [2:0] op;
    logic       ill;
    logic       mm;
  } exp_t;

  vec_t tbl [0:12];
  exp_t sbq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (sel=%0d)", name, act, exp, sel);
    end
  endtask

  // One full transaction on the selected instance, with `hold` cycles of response backpressure.
  task automatic txn(input logic [7:0] ta, input logic [7:0] tb_in, input logic [2:0] top,
                     input logic [8:0] ts, input int hold);
    exp_t e;
    exp_t g;
    int   cyc;
    int   lat;
    logic [31:0] s0;
    logic [31:0] o0;
    @(negedge clk);
    a = ta; b = tb_in; op = top; vld = 1'b1;
    cyc = 0;
    while (m_req_ready != 32'd1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready before accept", m_req_ready, 32'd1);
    @(posedge clk);
    e.ill = (top == 3'd7);
    e.op  = top;
    e.s   = (e.ill || corrupt) ? 9'd0 : ts;
    e.mm  = !e.ill && (sel != 2) && corrupt && (ts != 9'd0);
    sbq.push_back(e);
    if (e.mm && exp_err[sel] < 255) exp_err[sel]++;
    #1;
    vld = 1'b0;
    chk("ula_en after accept", m_ula_en, 32'(!e.ill));
    lat = 0;
    while (m_rsp_valid != 32'd1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("response latency", 32'(lat), e.ill ? 32'd0 : (sel == 1 ? 32'd4 : 32'd1));
    chk("ula_en low in resp", m_ula_en, 32'd0);
    chk("ula_a kept", m_ula_a, 32'(ta));
    s0 = m_rsp_s;
    o0 = m_rsp_op;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vld = 1'b1;
      a   = 8'hA5;
      chk("req_ready low in resp", m_req_ready, 32'd0);
      chk("rsp_valid held", m_rsp_valid, 32'd1);
      chk("rsp_s stable", m_rsp_s, s0);
      chk("rsp_op stable", m_rsp_op, o0);
      chk("ula_en stays low", m_ula_en, 32'd0);
    end
    @(negedge clk);
    vld = 1'b0;
    rdy = 1'b1;
    chk("scoreboard has entry", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      g = sbq.pop_front();
      chk("rsp_s", m_rsp_s, 32'(g.s));
      chk("rsp_op", m_rsp_op, 32'(g.op));
      chk("rsp_illegal", m_ill, 32'(g.ill));
      chk("rsp_mismatch", m_mm, 32'(g.mm));
    end
    chk("err_cnt", m_err, 32'(exp_err[sel]));
    @(posedge clk);
    #1;
    rdy = 1'b0;
    chk("rsp_valid cleared", m_rsp_valid, 32'd0);
    chk("req_ready after handshake", m_req_ready, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_err[0] = 0; exp_err[1] = 0; exp_err[2] = 0;
    vld = 1'b0; rdy = 1'b0; a = 8'd0; b = 8'd0; op = 3'd0; corrupt = 1'b0; sel = 0;

    tbl[0]  = '{8'd55,  8'd10,  3'd0, 9'd65};
    tbl[1]  = '{8'd10,  8'd55,  3'd1, 9'h1D3};
    tbl[2]  = '{8'd255, 8'd255, 3'd0, 9'h1FE};
    tbl[3]  = '{8'd55,  8'd100, 3'd2, 9'd0};
    tbl[4]  = '{8'd10,  8'd10,  3'd4, 9'd1};
    tbl[5]  = '{8'd100, 8'd12,  3'd5, 9'd0};
    tbl[6]  = '{8'd10,  8'd10,  3'd6, 9'd1};
    tbl[7]  = '{8'd3,   8'd7,   3'd3, 9'd1};
    tbl[8]  = '{8'd0,   8'd1,   3'd1, 9'h1FF};
    tbl[9]  = '{8'd200, 8'd100, 3'd2, 9'd1};
    tbl[10] = '{8'd7,   8'd7,   3'd3, 9'd0};
    tbl[11] = '{8'd255, 8'd0,   3'd1, 9'h0FF};
    tbl[12] = '{8'd9,   8'd4,   3'd7, 9'd0};

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ula_a", m_ula_a, 32'd0);
    chk("reset ula_en", m_ula_en, 32'd0);
    chk("reset rsp_valid", m_rsp_valid, 32'd0);
    chk("reset rsp_s", m_rsp_s, 32'd0);
    chk("reset rsp_op", m_rsp_op, 32'd0);
    chk("reset rsp_mismatch", m_mm, 32'd0);
    chk("reset rsp_illegal", m_ill, 32'd0);
    chk("reset err_cnt", m_err, 32'd0);
    chk("reset busy", m_busy, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready out of reset", m_req_ready, 32'd1);

    // Table vectors on SETTLE=1 with a correct ULA.
    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].s, i % 3);
    end

    // Long backpressure; a waiting request must not be taken before the handshake.
    txn(8'd55, 8'd10, 3'd0, 9'd65, 5);
    txn(tbl[1].a, tbl[1].b, tbl[1].op, tbl[1].s, 0);

    // Broken ULA: mismatch flagged, err_cnt counts and saturates.
    corrupt = 1'b1;
    txn(8'd55, 8'd10, 3'd0, 9'd65, 0);
    chk("err_cnt after first mismatch", m_err, 32'd1);
    for (int i = 1; i < 300; i++) begin
      txn(8'd55, 8'd10, 3'd0, 9'd65, 0);
    end
    chk("err_cnt saturated", m_err, 32'd255);

    // CHECK=0 instance never flags or counts.
    sel = 2;
    for (int i = 0; i < 3; i++) begin
      txn(8'd55, 8'd10, 3'd0, 9'd65, 0);
    end
    chk("err_cnt frozen with CHECK=0", m_err, 32'd0);
    corrupt = 1'b0;

    // SETTLE=4 instance.
    sel = 1;
    txn(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].s, 1);
    txn(tbl[12].a, tbl[12].b, tbl[12].op, tbl[12].s, 0);
    txn(tbl[2].a, tbl[2].b, tbl[2].op, tbl[2].s, 2);

    // Reset during DRIVE: everything returns to reset values at once, nothing is delivered.
    @(negedge clk);
    a = 8'd55; b = 8'd10; op = 3'd0; vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    chk("busy in drive", m_busy, 32'd1);
    chk("ula_en in drive", m_ula_en, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ula_en at reset", m_ula_en, 32'd0);
    chk("busy at reset", m_busy, 32'd0);
    chk("rsp_valid at reset", m_rsp_valid, 32'd0);
    chk("err_cnt of saturated instance cleared", 32'(err0), 32'd0);
    exp_err[0] = 0; exp_err[1] = 0; exp_err[2] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no response after reset", m_rsp_valid, 32'd0);
      chk("req_ready after reset", m_req_ready, 32'd1);
    end
    txn(tbl[1].a, tbl[1].b, tbl[1].op, tbl[1].s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
